// File: rtl/axi4_mem_responder_be512x64_if.sv
// AXI4 channel bundle between the cache backend master and the memory responder.
// Sideband lock/cache/prot/qos/region fields are carried but ignored by the slave.
interface axi4_mem_responder_be512x64_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 1
);
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;
  logic              arlock;
  logic [3:0]        arcache, arqos, arregion;
  logic [2:0]        arprot;

  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  logic              awlock;
  logic [3:0]        awcache, awqos, awregion;
  logic [2:0]        awprot;

  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, arregion,
    input  arready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos, awregion,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos, arregion,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos, awregion,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi4_mem_responder_be512x64.sv
// AXI4 slave word memory for the cache backend port: independent read/write engines on one RAM.
// Define AXI4_MEM_RESPONDER_WRAP_BURST_EN to support WRAP bursts (len 1/3/7/15).
module axi4_mem_responder_be512x64 #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 1,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic ap_clk,
  input  logic areset_n,
  axi4_mem_responder_be512x64_if.slave s_axi,
  output logic [1:0] rd_state,
  output logic [1:0] wr_state
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_BURST = 2'd1} rd_st_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_st_t;

  // WRAP keeps the upper index bits and lets the low log2(len+1) bits roll over.
  function automatic idx_t next_idx(input idx_t idx, input logic wrap, input logic [3:0] len_lo);
    idx_t mask, inc;
    mask = idx_t'(len_lo);
    inc  = idx + idx_t'(1);
    return wrap ? ((idx & ~mask) | (inc & mask)) : inc;
  endfunction

  // Returns {wrap, slverr}; anything not natively supported still runs as INCR.
  function automatic logic [1:0] burst_mode(input logic [2:0] size, input logic [1:0] burst,
                                            input logic [7:0] len);
    logic wrap, err;
    wrap = 1'b0;
    err  = (size != 3'd6);
`ifdef AXI4_MEM_RESPONDER_WRAP_BURST_EN
    if (burst == 2'd2) begin
      wrap = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      err  = err || !wrap;
    end else if (burst != 2'd1) begin
      err = 1'b1;
    end
`else
    begin
      logic unused_len;
      unused_len = ^len;
      err = err || (burst != 2'd1);
    end
`endif
    return {wrap, err};
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  rd_st_t     rd_st;
  idx_t       fetch_idx;
  logic [7:0] rd_len, fetch_cnt;
  logic       fetch_done, ram_v, ram_last, rd_wrap, rd_err;
  logic       out_load, ram_adv, ram_en;

  wr_st_t     wr_st;
  idx_t       wr_idx;
  logic [7:0] wr_len, wr_cnt;
  logic       wr_wrap, wr_err, wr_en, wr_beat_last, wlast_bad;

  logic [1:0] ar_mode, aw_mode;

  assign ar_mode = burst_mode(s_axi.arsize, s_axi.arburst, s_axi.arlen);
  assign aw_mode = burst_mode(s_axi.awsize, s_axi.awburst, s_axi.awlen);

  // Two-stage read pipe (RAM register, output register); both stages stall together.
  assign out_load = ram_v && (!s_axi.rvalid || s_axi.rready);
  assign ram_adv  = !ram_v || out_load;
  assign ram_en   = (rd_st == R_BURST) && ram_adv && !fetch_done;

  assign wr_en        = (wr_st == W_DATA) && s_axi.wvalid && s_axi.wready;
  assign wr_beat_last = (wr_cnt == wr_len);
  assign wlast_bad    = (s_axi.wlast != wr_beat_last);

  assign rd_state = rd_st;
  assign wr_state = wr_st;

  // Non-blocking read and write in one block give read-first behaviour on a collision.
  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      for (int b = 0; b < LANES; b++) begin
        if (s_axi.wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
    if (ram_en) ram_q <= mem[fetch_idx];
  end

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      rd_st         <= R_IDLE;
      s_axi.arready <= 1'b1;
      s_axi.rvalid  <= 1'b0;
      s_axi.rlast   <= 1'b0;
      s_axi.rresp   <= 2'd0;
      s_axi.rid     <= '0;
      s_axi.rdata   <= '0;
      fetch_idx     <= '0;
      rd_len        <= '0;
      fetch_cnt     <= '0;
      fetch_done    <= 1'b0;
      ram_v         <= 1'b0;
      ram_last      <= 1'b0;
      rd_wrap       <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      case (rd_st)
        R_IDLE: begin
          if (s_axi.arvalid && s_axi.arready) begin
            fetch_idx     <= s_axi.araddr[DEPTH_LOG2+5:6];
            rd_len        <= s_axi.arlen;
            s_axi.rid     <= s_axi.arid;
            rd_wrap       <= ar_mode[1];
            rd_err        <= ar_mode[0];
            fetch_cnt     <= '0;
            fetch_done    <= 1'b0;
            ram_v         <= 1'b0;
            s_axi.arready <= 1'b0;
            rd_st         <= R_BURST;
          end
        end
        R_BURST: begin
          if (ram_adv) begin
            ram_v <= ram_en;
            if (ram_en) begin
              ram_last   <= (fetch_cnt == rd_len);
              fetch_done <= (fetch_cnt == rd_len);
              fetch_idx  <= next_idx(fetch_idx, rd_wrap, rd_len[3:0]);
              fetch_cnt  <= fetch_cnt + 8'd1;
            end
          end
          if (out_load) begin
            s_axi.rvalid <= 1'b1;
            s_axi.rdata  <= ram_q;
            s_axi.rlast  <= ram_last;
            s_axi.rresp  <= rd_err ? 2'd2 : 2'd0;
          end else if (s_axi.rvalid && s_axi.rready) begin
            s_axi.rvalid <= 1'b0;
            s_axi.rlast  <= 1'b0;
          end
          if (s_axi.rvalid && s_axi.rready && s_axi.rlast) begin
            s_axi.arready <= 1'b1;
            rd_st         <= R_IDLE;
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  // A wlast mismatch only flags the response; the burst always runs len+1 beats.
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_st         <= W_IDLE;
      s_axi.awready <= 1'b1;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'd0;
      s_axi.bid     <= '0;
      wr_idx        <= '0;
      wr_len        <= '0;
      wr_cnt        <= '0;
      wr_wrap       <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      case (wr_st)
        W_IDLE: begin
          if (s_axi.awvalid && s_axi.awready) begin
            wr_idx        <= s_axi.awaddr[DEPTH_LOG2+5:6];
            wr_len        <= s_axi.awlen;
            s_axi.bid     <= s_axi.awid;
            wr_wrap       <= aw_mode[1];
            wr_err        <= aw_mode[0];
            wr_cnt        <= '0;
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b1;
            wr_st         <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_en) begin
            wr_idx <= next_idx(wr_idx, wr_wrap, wr_len[3:0]);
            wr_cnt <= wr_cnt + 8'd1;
            if (wlast_bad) wr_err <= 1'b1;
            if (wr_beat_last) begin
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              s_axi.bresp  <= (wr_err || wlast_bad) ? 2'd2 : 2'd0;
              wr_st        <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            wr_st         <= W_IDLE;
          end
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{s_axi.araddr[ADDR_W-1:DEPTH_LOG2+6], s_axi.araddr[5:0],
                             s_axi.awaddr[ADDR_W-1:DEPTH_LOG2+6], s_axi.awaddr[5:0],
                             s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion,
                             s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion};
endmodule

// File: tb/tb_axi4_mem_responder_be512x64.sv
// Directed bench for the AXI4 memory responder: drivers push expected R/B beats,
// concurrent monitors pop and compare on every handshake.
module tb_axi4_mem_responder_be512x64;
  localparam int DATA_W = 512;
  localparam int LANES  = DATA_W / 8;
  localparam int EW     = DATA_W + 4;

  logic ap_clk = 1'b0;
  logic areset_n;
  logic [1:0] rd_state, wr_state;

  axi4_mem_responder_be512x64_if axi();

  axi4_mem_responder_be512x64 dut (
    .ap_clk   (ap_clk),
    .areset_n (areset_n),
    .s_axi    (axi.slave),
    .rd_state (rd_state),
    .wr_state (wr_state)
  );

  always #5 ap_clk = ~ap_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int r_beats = 0;
  int rready_mode = 0;

  logic [EW-1:0]     exp_r_q[$];
  logic [2:0]        exp_b_q[$];
  logic [DATA_W-1:0] wr_data[16];
  logic [LANES-1:0]  wr_strb[16];

  task automatic check(input string name, input logic [DATA_W+7:0] act, input logic [DATA_W+7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic push_r(input logic id, input logic [1:0] resp, input logic last, input logic [DATA_W-1:0] d);
    exp_r_q.push_back({id, resp, last, d});
  endtask

  function automatic logic ready_of(input int ch);
    case (ch)
      0:       return axi.arready;
      1:       return axi.awready;
      default: return axi.wready;
    endcase
  endfunction

  // Returns at posedge+1 of the handshake edge.
  task automatic wait_ready(input int ch, input string name);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!ready_of(ch) && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (!ready_of(ch)) fail_now(name);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic axi_write(input logic [63:0] addr, input int len, input int wlast_at,
                           input logic id, input logic [1:0] exp_resp);
    int n;
    exp_b_q.push_back({id, exp_resp});
    @(posedge ap_clk);
    #1;
    axi.awaddr  = addr;
    axi.awlen   = 8'(len);
    axi.awsize  = 3'd6;
    axi.awburst = 2'd1;
    axi.awid    = id;
    axi.awvalid = 1'b1;
    wait_ready(1, "aw_ready");
    axi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      axi.wvalid = 1'b1;
      axi.wdata  = wr_data[i];
      axi.wstrb  = wr_strb[i];
      axi.wlast  = (i == wlast_at);
      wait_ready(2, "w_ready");
    end
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
    @(negedge ap_clk);
    check("w_ready_after_last", axi.wready, 0);
    n = 0;
    while (exp_b_q.size() != 0 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (exp_b_q.size() != 0) begin
      fail_now("b_timeout");
      exp_b_q.delete();
    end
  endtask

  task automatic issue_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id);
    @(posedge ap_clk);
    #1;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arsize  = size;
    axi.arburst = burst;
    axi.arid    = id;
    axi.arvalid = 1'b1;
    wait_ready(0, "ar_ready");
    axi.arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input bit check_lat);
    int n;
    issue_ar(addr, len, size, burst, id);
    if (check_lat) begin
      @(negedge ap_clk); check("r_latency_c1", axi.rvalid, 0);
      @(negedge ap_clk); check("r_latency_c2", axi.rvalid, 0);
      @(negedge ap_clk); check("r_latency_c3", axi.rvalid, 1);
    end
    n = 0;
    while (exp_r_q.size() != 0 && n < 300) begin
      @(negedge ap_clk);
      n++;
    end
    if (exp_r_q.size() != 0) begin
      fail_now("r_timeout");
      exp_r_q.delete();
    end
  endtask

  // R monitor: scoreboard pop on handshake, stability check while stalled.
  logic          stall_prev = 1'b0;
  logic [EW-1:0] r_prev;
  always @(negedge ap_clk) begin
    logic [EW-1:0] act, e;
    act = {axi.rid, axi.rresp, axi.rlast, axi.rdata};
    if (!areset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("r_stall_valid", axi.rvalid, 1);
        check("r_stall_hold", act, r_prev);
      end
      if (axi.rvalid && axi.rready) begin
        r_beats++;
        if (exp_r_q.size() == 0) begin
          check("r_unexpected_beat", act, '0);
        end else begin
          e = exp_r_q.pop_front();
          check("r_beat", act, e);
        end
      end
      stall_prev = axi.rvalid && !axi.rready;
      r_prev     = act;
    end
  end

  always @(negedge ap_clk) begin
    logic [2:0] e;
    if (areset_n && axi.bvalid && axi.bready) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected", {axi.bid, axi.bresp}, 3'b000);
      end else begin
        e = exp_b_q.pop_front();
        check("b_resp", {axi.bid, axi.bresp}, e);
      end
    end
  end

  initial begin
    int ph;
    ph = 0;
    axi.rready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      if (rready_mode == 0) begin
        axi.rready = 1'b1;
      end else begin
        axi.rready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  initial begin
    int n, rb0;
    logic seen;
    areset_n    = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd6; axi.arburst = 2'd1;
    axi.arid = '0; axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arqos = '0; axi.arregion = '0;
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd6; axi.awburst = 2'd1;
    axi.awid = '0; axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awqos = '0; axi.awregion = '0;
    axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.bready = 1'b1;
    for (int i = 0; i < 16; i++) wr_strb[i] = '1;

    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_arready", axi.arready, 1);
    check("rst_awready", axi.awready, 1);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_wready", axi.wready, 0);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rlast", axi.rlast, 0);
    check("rst_resp", {axi.rresp, axi.bresp, axi.rid, axi.bid}, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_states", {rd_state, wr_state}, 0);
    @(negedge ap_clk);
    areset_n = 1'b1;

    // 4-beat write/read round trip at word 64, id echoed, 2-cycle read latency
    for (int i = 0; i < 4; i++) wr_data[i] = DATA_W'(i);
    axi_write(64'h1000, 3, 3, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) push_r(1'b1, 2'd0, i == 3, DATA_W'(i));
    axi_read(64'h1000, 8'd3, 3'd6, 2'd1, 1'b1, 1'b1);

    // 8-beat read with rready pattern 1,0,0
    for (int i = 0; i < 8; i++) wr_data[i] = DATA_W'(32'h100 + i);
    axi_write(64'h4000, 7, 7, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) push_r(1'b0, 2'd0, i == 7, DATA_W'(32'h100 + i));
    rready_mode = 1;
    axi_read(64'h4000, 8'd7, 3'd6, 2'd1, 1'b0, 1'b0);
    rready_mode = 0;

    // byte strobes: only lanes 0-3 overwrite an all-ones word
    wr_data[0] = '1;
    axi_write(64'h2000, 0, 0, 1'b0, 2'd0);
    wr_data[0] = {16{32'hDEADBEEF}};
    wr_strb[0] = LANES'(16'h000F);
    axi_write(64'h2000, 0, 0, 1'b1, 2'd0);
    wr_strb[0] = '1;
    push_r(1'b0, 2'd0, 1'b1, {{(DATA_W-32){1'b1}}, 32'hDEADBEEF});
    axi_read(64'h2000, 8'd0, 3'd6, 2'd1, 1'b0, 1'b0);

    // early wlast: SLVERR, but all four beats land in memory
    for (int i = 0; i < 4; i++) wr_data[i] = DATA_W'(32'h300 + i);
    axi_write(64'h3000, 3, 1, 1'b0, 2'd2);
    for (int i = 0; i < 4; i++) push_r(1'b0, 2'd0, i == 3, DATA_W'(32'h300 + i));
    axi_read(64'h3000, 8'd3, 3'd6, 2'd1, 1'b0, 1'b0);

    // words 4..9 hold 0xA04..0xA09, then a WRAP read starting at word 6
    for (int i = 0; i < 6; i++) wr_data[i] = DATA_W'(32'hA04 + i);
    axi_write(64'h100, 5, 5, 1'b0, 2'd0);
`ifdef AXI4_MEM_RESPONDER_WRAP_BURST_EN
    push_r(1'b1, 2'd0, 1'b0, DATA_W'(32'hA06));
    push_r(1'b1, 2'd0, 1'b0, DATA_W'(32'hA07));
    push_r(1'b1, 2'd0, 1'b0, DATA_W'(32'hA04));
    push_r(1'b1, 2'd0, 1'b1, DATA_W'(32'hA05));
`else
    push_r(1'b1, 2'd2, 1'b0, DATA_W'(32'hA06));
    push_r(1'b1, 2'd2, 1'b0, DATA_W'(32'hA07));
    push_r(1'b1, 2'd2, 1'b0, DATA_W'(32'hA08));
    push_r(1'b1, 2'd2, 1'b1, DATA_W'(32'hA09));
`endif
    axi_read(64'h180, 8'd3, 3'd6, 2'd2, 1'b1, 1'b0);

    // bad arsize, then FIXED burst: both run as INCR with SLVERR
    push_r(1'b0, 2'd2, 1'b0, DATA_W'(0));
    push_r(1'b0, 2'd2, 1'b1, DATA_W'(1));
    axi_read(64'h1000, 8'd1, 3'd5, 2'd1, 1'b0, 1'b0);
    push_r(1'b1, 2'd2, 1'b0, DATA_W'(0));
    push_r(1'b1, 2'd2, 1'b1, DATA_W'(1));
    axi_read(64'h1000, 8'd1, 3'd6, 2'd0, 1'b1, 1'b0);

    // reset asserted while beat 2 of an 8-beat read is presented
    rb0 = r_beats;
    for (int i = 0; i < 8; i++) push_r(1'b0, 2'd0, i == 7, DATA_W'(32'h100 + i));
    issue_ar(64'h4000, 8'd7, 3'd6, 2'd1, 1'b0);
    n = 0;
    while (!(axi.rvalid && r_beats == rb0 + 2) && n < 50) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (!(axi.rvalid && r_beats == rb0 + 2)) fail_now("r_beat2_wait");
    areset_n = 1'b0;
    #1;
    check("midrst_rvalid", axi.rvalid, 0);
    check("midrst_arready", axi.arready, 1);
    check("midrst_rlast", axi.rlast, 0);
    exp_r_q.delete();
    repeat (3) @(negedge ap_clk);
    areset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge ap_clk);
      if (axi.rvalid) seen = 1'b1;
    end
    check("midrst_no_partial", seen, 0);

    // fresh traffic after the abort
    wr_data[0] = DATA_W'(32'h55);
    wr_data[1] = DATA_W'(32'h66);
    axi_write(64'h8000, 1, 1, 1'b1, 2'd0);
    push_r(1'b0, 2'd0, 1'b0, DATA_W'(32'h55));
    push_r(1'b0, 2'd0, 1'b1, DATA_W'(32'h66));
    axi_read(64'h8000, 8'd1, 3'd6, 2'd1, 1'b0, 1'b1);

    repeat (5) @(posedge ap_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
